fwd_select_ctrl: RTL and testbench

- Forwarding and load-use hazard controller for the 5-stage RV32I pipeline.
- Tracks the destination register, write-enable and load flag of the instructions in ID/EX, EX/MEM and MEM/WB in its own shadow registers.
- Generates the 2-bit select codes that drive the EX-stage operand 4:1 muxes: 00 = register file, 01 = MEM/WB (mem hazard), 10 = EX/MEM (ex hazard). Code 11 is never driven.
- Also issues the load-use stall to the PC/IF/ID registers and keeps a saturating stall counter for performance reporting.

---
 rtl/fwd_select_ctrl.sv | 126 ++++++++++++
 tb/tb_fwd_select_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_select_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_select_ctrl
//  Function : EX-stage operand forwarding selects and load-use stall control
//             for a 5-stage RV32I pipeline, with a saturating stall counter.
//  Revision : 1.0
// ============================================================================
module fwd_select_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [REG_AW-1:0] c_x0      = '0;
    localparam logic [CNT_W-1:0]  c_cnt_max = '1;
    localparam logic [CNT_W-1:0]  c_cnt_one = CNT_W'(1);
    localparam logic [1:0]        c_sel_rf  = 2'b00;
    localparam logic [1:0]        c_sel_wb  = 2'b01;
    localparam logic [1:0]        c_sel_mem = 2'b10;

    // Shadow copies of the pipeline registers that matter for hazards
    logic [REG_AW-1:0] r_ex_rs1;
    logic [REG_AW-1:0] r_ex_rs2;
    logic [REG_AW-1:0] r_ex_rd;
    logic              r_ex_rw;
    logic              r_ex_mr;
    logic [REG_AW-1:0] r_mem_rd;
    logic              r_mem_rw;
    logic [REG_AW-1:0] r_wb_rd;
    logic              r_wb_rw;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic              w_stall;
    logic              w_issue;
    logic [1:0]        w_fwd_a;
    logic [1:0]        w_fwd_b;

    // Newest producer wins; x0 is hard-wired zero and is never forwarded.
    function automatic logic [1:0] sel_for(
        input logic [REG_AW-1:0] rs,
        input logic              mem_rw,
        input logic [REG_AW-1:0] mem_rd,
        input logic              wb_rw,
        input logic [REG_AW-1:0] wb_rd
    );
        logic [1:0] sel;
        sel = c_sel_rf;
        if (mem_rw && (mem_rd != c_x0) && (mem_rd == rs)) begin
            sel = c_sel_mem;
        end else if (wb_rw && (wb_rd != c_x0) && (wb_rd == rs)) begin
            sel = c_sel_wb;
        end
        return sel;
    endfunction

    always_comb begin
        w_stall = 1'b0;
        if (r_ex_mr && (r_ex_rd != c_x0) && id_valid && !flush &&
            ((r_ex_rd == id_rs1) || (r_ex_rd == id_rs2))) begin
            w_stall = 1'b1;
        end
        w_issue = id_valid && !flush && !w_stall;
    end

    always_comb begin
        w_fwd_a = sel_for(r_ex_rs1, r_mem_rw, r_mem_rd, r_wb_rw, r_wb_rd);
        w_fwd_b = sel_for(r_ex_rs2, r_mem_rw, r_mem_rd, r_wb_rw, r_wb_rd);
    end

    // The shift never pauses; a stall or flush only turns the EX slot into a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ex_rs1    <= '0;
            r_ex_rs2    <= '0;
            r_ex_rd     <= '0;
            r_ex_rw     <= 1'b0;
            r_ex_mr     <= 1'b0;
            r_mem_rd    <= '0;
            r_mem_rw    <= 1'b0;
            r_wb_rd     <= '0;
            r_wb_rw     <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            if (w_issue) begin
                r_ex_rs1 <= id_rs1;
                r_ex_rs2 <= id_rs2;
                r_ex_rd  <= id_rd;
                r_ex_rw  <= id_regwrite;
                r_ex_mr  <= id_memread;
            end else begin
                r_ex_rs1 <= '0;
                r_ex_rs2 <= '0;
                r_ex_rd  <= '0;
                r_ex_rw  <= 1'b0;
                r_ex_mr  <= 1'b0;
            end
            r_mem_rd <= r_ex_rd;
            r_mem_rw <= r_ex_rw;
            r_wb_rd  <= r_mem_rd;
            r_wb_rw  <= r_mem_rw;
            if (w_stall && (r_stall_cnt != c_cnt_max)) begin
                r_stall_cnt <= r_stall_cnt + c_cnt_one;
            end
        end
    end

    assign fwd_a     = w_fwd_a;
    assign fwd_b     = w_fwd_b;
    assign stall     = w_stall;
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fwd_select_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fwd_select_ctrl
//  Function : Self-checking bench for fwd_select_ctrl (two counter widths).
//  Revision : 1.0
// ============================================================================
module tb_fwd_select_ctrl;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] id_rd;
    logic       id_regwrite;
    logic       id_memread;
    logic       flush;
    logic [1:0] fwd_a, fwd_b, fwd_a2, fwd_b2;
    logic       stall, stall2;
    logic [15:0] stall_cnt;
    logic [1:0]  stall_cnt2;

    int n_assert = 0;
    int n_fail   = 0;

    fwd_select_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .stall_cnt(stall_cnt)
    );

    fwd_select_ctrl #(.REG_AW(5), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
        .fwd_a(fwd_a2), .fwd_b(fwd_b2), .stall(stall2), .stall_cnt(stall_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // hist[0] is the instruction now in EX, hist[1] one cycle older, hist[2] two.
    typedef struct {
        logic       w;
        logic       m;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } rec_t;

    rec_t hist[$];
    int   m_stalls = 0;

    function automatic rec_t bubble();
        rec_t r;
        r.w = 1'b0; r.m = 1'b0; r.rd = '0; r.rs1 = '0; r.rs2 = '0;
        return r;
    endfunction

    function automatic logic [1:0] exp_sel(input logic [4:0] rs);
        // Search older instructions newest-first for one that writes rs.
        for (int age = 1; age <= 2; age++) begin
            if (hist[age].w && hist[age].rd != 0 && hist[age].rd == rs)
                return (age == 1) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    initial begin
        for (int i = 0; i < 3; i++) hist.push_back(bubble());
    end

    always @(negedge clk) begin
        logic e_stall;
        rec_t enter;
        if (!rst) begin
            hist.delete();
            for (int i = 0; i < 3; i++) hist.push_back(bubble());
            m_stalls = 0;
            check("rst_fwd_a", {30'b0, fwd_a}, 0);
            check("rst_fwd_b", {30'b0, fwd_b}, 0);
            check("rst_stall", {31'b0, stall}, 0);
            check("rst_cnt",   {16'b0, stall_cnt}, 0);
            check("rst_cnt2",  {30'b0, stall_cnt2}, 0);
        end else begin
            e_stall = hist[0].m && hist[0].rd != 0 && id_valid && !flush &&
                      (hist[0].rd == id_rs1 || hist[0].rd == id_rs2);
            check("fwd_a",  {30'b0, fwd_a}, {30'b0, exp_sel(hist[0].rs1)});
            check("fwd_b",  {30'b0, fwd_b}, {30'b0, exp_sel(hist[0].rs2)});
            check("stall",  {31'b0, stall}, {31'b0, e_stall});
            check("cnt",    {16'b0, stall_cnt}, (m_stalls > 65535) ? 65535 : m_stalls);
            check("cnt2",   {30'b0, stall_cnt2}, (m_stalls > 3) ? 3 : m_stalls);
            if (id_valid && !flush && !e_stall) begin
                enter.w = id_regwrite; enter.m = id_memread; enter.rd = id_rd;
                enter.rs1 = id_rs1; enter.rs2 = id_rs2;
            end else begin
                enter = bubble();
            end
            if (e_stall) m_stalls++;
            hist.push_front(enter);
            void'(hist.pop_back());
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic issue(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic rw, input logic mr, input logic fl);
        @(posedge clk);
        #1;
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_regwrite = rw; id_memread = mr; flush = fl;
    endtask

    task automatic nop();
        issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        issue(1'b1, rs1, rs2, rd, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic load(input logic [4:0] rd, input logic [4:0] rs1);
        issue(1'b1, rs1, 5'd0, rd, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic drain();
        repeat (3) nop();
    endtask

    initial begin
        rst = 1'b0;
        id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_regwrite = 1'b0; id_memread = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // independent adds
        alu(5'd1, 5'd3, 5'd4);
        alu(5'd2, 5'd3, 5'd4);
        nop();
        @(negedge clk);
        check("nohaz_a", {30'b0, fwd_a}, 2'b00);
        check("nohaz_b", {30'b0, fwd_b}, 2'b00);
        check("nohaz_stall", {31'b0, stall}, 0);
        drain();

        // EX hazard on rs1, then on rs2
        alu(5'd5, 5'd1, 5'd2);
        alu(5'd9, 5'd5, 5'd0);
        nop();
        @(negedge clk);
        check("exhaz_a", {30'b0, fwd_a}, 2'b10);
        drain();
        alu(5'd5, 5'd1, 5'd2);
        alu(5'd9, 5'd0, 5'd5);
        nop();
        @(negedge clk);
        check("exhaz_b", {30'b0, fwd_b}, 2'b10);
        drain();

        // both stages match: newest wins; then MEM/WB-only match
        alu(5'd6, 5'd1, 5'd2);
        alu(5'd6, 5'd1, 5'd2);
        alu(5'd10, 5'd6, 5'd0);
        nop();
        @(negedge clk);
        check("prio_a", {30'b0, fwd_a}, 2'b10);
        drain();
        alu(5'd6, 5'd1, 5'd2);
        nop();
        alu(5'd10, 5'd6, 5'd0);
        nop();
        @(negedge clk);
        check("memhaz_a", {30'b0, fwd_a}, 2'b01);
        drain();

        // load-use: one stall, the add is held in ID, then gets 01
        load(5'd7, 5'd1);
        alu(5'd11, 5'd3, 5'd7);
        @(negedge clk);
        check("lu_stall", {31'b0, stall}, 1);
        check("lu_cnt0", {16'b0, stall_cnt}, 0);
        alu(5'd11, 5'd3, 5'd7);
        @(negedge clk);
        check("lu_stall_end", {31'b0, stall}, 0);
        check("lu_cnt1", {16'b0, stall_cnt}, 1);
        nop();
        @(negedge clk);
        check("lu_fwd_b", {30'b0, fwd_b}, 2'b01);
        check("lu_fwd_a", {30'b0, fwd_a}, 2'b00);
        drain();

        // x0 never forwards
        alu(5'd0, 5'd1, 5'd2);
        alu(5'd14, 5'd0, 5'd3);
        nop();
        @(negedge clk);
        check("x0_a", {30'b0, fwd_a}, 2'b00);
        drain();

        // flushed dependent of a load: no stall, and it never reaches EX
        load(5'd8, 5'd1);
        issue(1'b1, 5'd8, 5'd0, 5'd12, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check("flush_stall", {31'b0, stall}, 0);
        alu(5'd13, 5'd12, 5'd0);
        nop();
        @(negedge clk);
        check("flush_bubble_a", {30'b0, fwd_a}, 2'b00);
        check("flush_cnt", {16'b0, stall_cnt}, 1);
        drain();

        // four more load-use stalls: narrow counter saturates at 3
        for (int i = 0; i < 4; i++) begin
            load(5'd7, 5'd1);
            alu(5'd11, 5'd3, 5'd7);
            alu(5'd11, 5'd3, 5'd7);
            nop();
            @(negedge clk);
            if (i == 2) check("sat_cnt2_at4", {30'b0, stall_cnt2}, 3);
        end
        check("sat_cnt2_hold", {30'b0, stall_cnt2}, 3);
        check("sat_cnt_wide", {16'b0, stall_cnt}, 5);
        drain();

        // async reset mid-stream with forwarding active
        alu(5'd5, 5'd1, 5'd2);
        alu(5'd12, 5'd5, 5'd5);
        nop();
        #1;
        check("pre_rst_a", {30'b0, fwd_a}, 2'b10);
        check("pre_rst_b", {30'b0, fwd_b}, 2'b10);
        #1 rst = 1'b0;
        #1;
        check("async_rst_a", {30'b0, fwd_a}, 2'b00);
        check("async_rst_b", {30'b0, fwd_b}, 2'b00);
        check("async_rst_stall", {31'b0, stall}, 0);
        check("async_rst_cnt", {16'b0, stall_cnt}, 0);
        check("async_rst_cnt2", {30'b0, stall_cnt2}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        alu(5'd13, 5'd5, 5'd5);
        nop();
        @(negedge clk);
        check("post_rst_a", {30'b0, fwd_a}, 2'b00);
        check("post_rst_b", {30'b0, fwd_b}, 2'b00);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
